// File: rtl/fc_pkg.sv
// Shared definitions for the FC frame scheduler and the FC/argmax unit:
// controller state encoding, default frame geometry and index sizing.
package fc_pkg;

    localparam int unsigned FC_IN_DIM  = 32;
    localparam int unsigned FC_TIMEOUT = 64;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StStream = 2'd1,
        StWait   = 2'd2,
        StResult = 2'd3
    } fc_state_e;

    // Index width that stays legal for a one-entry range.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_buffer.sv
// Feature frame buffer: upstream write port with wrap-around write index,
// full flag, and a combinational read port indexed by the scheduler.
module frame_buffer
    import fc_pkg::*;
#(
    parameter int unsigned IN_DIM = FC_IN_DIM,
    localparam int unsigned AW    = idx_width(IN_DIM)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    wr_data,
    input  logic          wr_valid,
    input  logic          clr_full,
    input  logic [AW-1:0] rd_idx,
    output logic          full,
    output logic [7:0]    rd_data
);

    logic [7:0]    mem_q [IN_DIM];
    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic          full_q, full_d;
    logic          wr_fire;

    assign wr_fire = wr_valid & ~full_q;

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        full_d   = full_q;
        if (clr_full) begin
            full_d = 1'b0;
        end
        if (wr_fire) begin
            if (wr_cnt_q == AW'(IN_DIM - 1)) begin
                wr_cnt_d = '0;
                full_d   = 1'b1;
            end else begin
                wr_cnt_d = wr_cnt_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            full_q   <= full_d;
        end
    end

    // Payload storage carries no reset; the full flag guards its validity.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_cnt_q] <= wr_data;
        end
    end

    assign full    = full_q;
    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/fc_frame_scheduler.sv
// Frame scheduler: buffers one feature frame, streams it to the FC unit,
// waits (with timeout) for the class result and hands it to the consumer.
module fc_frame_scheduler
    import fc_pkg::*;
#(
    parameter int unsigned IN_DIM  = FC_IN_DIM,
    parameter int unsigned TIMEOUT = FC_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         s_data,
    input  logic               s_valid,
    output logic               s_ready,
    output logic [7:0]         fc_in_data,
    output logic               fc_in_valid,
    input  logic [3:0]         fc_class_out,
    input  logic signed [31:0] fc_class_value,
    input  logic               fc_class_valid,
    output logic [3:0]         m_class,
    output logic signed [31:0] m_value,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               busy,
    output logic [15:0]        frame_cnt,
    output logic               err
);

    localparam int unsigned AW = idx_width(IN_DIM);
    localparam int unsigned TW = idx_width(TIMEOUT);

    fc_state_e          state_q, state_d;
    logic [AW-1:0]      rd_cnt_q, rd_cnt_d;
    logic [TW-1:0]      wait_cnt_q, wait_cnt_d;
    logic [3:0]         m_class_q, m_class_d;
    logic signed [31:0] m_value_q, m_value_d;
    logic               m_valid_q, m_valid_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic               err_q, err_d;
    logic               clr_full;
    logic               full;
    logic [7:0]         buf_rd_data;

    frame_buffer #(
        .IN_DIM (IN_DIM)
    ) u_frame_buffer (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_data  (s_data),
        .wr_valid (s_valid),
        .clr_full (clr_full),
        .rd_idx   (rd_cnt_q),
        .full     (full),
        .rd_data  (buf_rd_data)
    );

    always_comb begin
        state_d     = state_q;
        rd_cnt_d    = rd_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        m_class_d   = m_class_q;
        m_value_d   = m_value_q;
        m_valid_d   = m_valid_q;
        frame_cnt_d = frame_cnt_q;
        err_d       = err_q;
        clr_full    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (full) begin
                    state_d  = StStream;
                    rd_cnt_d = '0;
                end
            end
            StStream: begin
                if (rd_cnt_q == AW'(IN_DIM - 1)) begin
                    rd_cnt_d   = '0;
                    wait_cnt_d = '0;
                    clr_full   = 1'b1;
                    state_d    = StWait;
                end else begin
                    rd_cnt_d = rd_cnt_q + AW'(1);
                end
            end
            StWait: begin
                // A result pulse in the final WAIT cycle beats the timeout.
                if (fc_class_valid) begin
                    m_class_d  = fc_class_out;
                    m_value_d  = fc_class_value;
                    m_valid_d  = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = StResult;
                end else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
                    err_d      = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = StIdle;
                end else begin
                    wait_cnt_d = wait_cnt_q + TW'(1);
                end
            end
            StResult: begin
                if (m_ready) begin
                    m_valid_d   = 1'b0;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = full ? StStream : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rd_cnt_q    <= '0;
            wait_cnt_q  <= '0;
            m_class_q   <= '0;
            m_value_q   <= '0;
            m_valid_q   <= 1'b0;
            frame_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_cnt_q    <= rd_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            m_class_q   <= m_class_d;
            m_value_q   <= m_value_d;
            m_valid_q   <= m_valid_d;
            frame_cnt_q <= frame_cnt_d;
            err_q       <= err_d;
        end
    end

    // s_ready is forced low while reset is asserted so every output reads 0.
    assign s_ready     = rst_n & ~full;
    assign fc_in_valid = (state_q == StStream);
    assign fc_in_data  = fc_in_valid ? buf_rd_data : 8'd0;
    assign m_class     = m_class_q;
    assign m_value     = m_value_q;
    assign m_valid     = m_valid_q;
    assign busy        = (state_q != StIdle);
    assign frame_cnt   = frame_cnt_q;
    assign err         = err_q;

endmodule
